// File: rtl/ct_mmu_sysmap_region_chk.sv
// Sysmap region checker: contiguous physical page regions with per-region
// attribute. Each lookup is resolved into a registered, back-pressured response.
`timescale 1ns/1ps
module ct_mmu_sysmap_region_chk #(
    parameter int                    NUM_REGION = 8,
    parameter int                    PA_WIDTH   = 28,
    parameter int                    ATTR_WIDTH = 5,
    parameter logic [ATTR_WIDTH-1:0] DFLT_ATTR  = {ATTR_WIDTH{1'b0}},
    localparam int                   IDX_W      = $clog2(NUM_REGION)
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  cfg_wen,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [PA_WIDTH-1:0]   cfg_top,
    input  logic [ATTR_WIDTH-1:0] cfg_attr,
    input  logic                  cfg_en,
    input  logic                  req_vld,
    input  logic [PA_WIDTH-1:0]   req_addr,
    output logic                  req_rdy,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_hit,
    output logic [IDX_W-1:0]      rsp_idx,
    output logic [ATTR_WIDTH-1:0] rsp_attr,
    output logic                  rsp_ge_top
);

    logic [PA_WIDTH-1:0]   top_r    [NUM_REGION];
    logic [ATTR_WIDTH-1:0] attr_r   [NUM_REGION];
    logic [NUM_REGION-1:0] en_r;

    logic [PA_WIDTH-1:0]   bottom_s [NUM_REGION];
    logic [NUM_REGION-1:0] match_s;
    logic [NUM_REGION-1:0] first_s;
    logic                  hit_s;
    logic [IDX_W-1:0]      idx_s;
    logic [ATTR_WIDTH-1:0] attr_or_s;
    logic [ATTR_WIDTH-1:0] attr_s;
    logic [PA_WIDTH-1:0]   last_top_s;
    logic                  any_en_s;
    logic                  ge_top_s;
    logic                  cfg_ok_s;
    logic                  accept_s;

    // Handshake: a new lookup is taken whenever the response slot is free or draining.
    assign req_rdy  = !rsp_vld || rsp_rdy;
    assign accept_s = req_vld && req_rdy;
    assign cfg_ok_s = (32'(cfg_idx) < NUM_REGION);

    // Region configuration registers; out-of-range indices are dropped.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < NUM_REGION; i++) begin
                top_r[i]  <= {PA_WIDTH{1'b0}};
                attr_r[i] <= {ATTR_WIDTH{1'b0}};
            end
            en_r <= {NUM_REGION{1'b0}};
        end else if (cfg_wen && cfg_ok_s) begin
            top_r[cfg_idx]  <= cfg_top;
            attr_r[cfg_idx] <= cfg_attr;
            en_r[cfg_idx]   <= cfg_en;
        end
    end

    // Region match vector; bottom of each region is the previous region's top.
    always_comb begin
        bottom_s[0] = {PA_WIDTH{1'b0}};
        for (int i = 1; i < NUM_REGION; i++) begin
            bottom_s[i] = top_r[i-1];
        end
        match_s = {NUM_REGION{1'b0}};
        for (int i = 0; i < NUM_REGION; i++) begin
            match_s[i] = en_r[i] && (req_addr >= bottom_s[i]) && (req_addr < top_r[i]);
        end
    end

    // Lowest-index winner, isolated as a one-hot so index/attr are plain OR-reductions.
    always_comb begin
        first_s   = match_s & (~match_s + {{(NUM_REGION-1){1'b0}}, 1'b1});
        hit_s     = |match_s;
        idx_s     = {IDX_W{1'b0}};
        attr_or_s = {ATTR_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGION; i++) begin
            idx_s     = idx_s | (first_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
            attr_or_s = attr_or_s | ({ATTR_WIDTH{first_s[i]}} & attr_r[i]);
        end
        attr_s = hit_s ? attr_or_s : DFLT_ATTR;
    end

    // Top of the highest-indexed enabled region; nothing enabled means everything is above.
    always_comb begin
        last_top_s = {PA_WIDTH{1'b0}};
        any_en_s   = 1'b0;
        for (int i = 0; i < NUM_REGION; i++) begin
            last_top_s = en_r[i] ? top_r[i] : last_top_s;
            any_en_s   = any_en_s | en_r[i];
        end
        ge_top_s = !any_en_s || (req_addr >= last_top_s);
    end

    // Response register: loaded on accept, held under back-pressure, freed by rsp_rdy.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rsp_vld    <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_idx    <= {IDX_W{1'b0}};
            rsp_attr   <= DFLT_ATTR;
            rsp_ge_top <= 1'b0;
        end else if (accept_s) begin
            rsp_vld    <= 1'b1;
            rsp_hit    <= hit_s;
            rsp_idx    <= idx_s;
            rsp_attr   <= attr_s;
            rsp_ge_top <= ge_top_s;
        end else if (rsp_rdy) begin
            rsp_vld    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ct_mmu_sysmap_region_chk.sv
// Directed self-checking bench for ct_mmu_sysmap_region_chk.
`timescale 1ns/1ps
module tb_ct_mmu_sysmap_region_chk;

    localparam logic [4:0] DA = 5'h1A;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst   = 1'b1;
    logic        cfg_wen  = 1'b0;
    logic [2:0]  cfg_idx  = 3'd0;
    logic [27:0] cfg_top  = 28'h0;
    logic [4:0]  cfg_attr = 5'd0;
    logic        cfg_en   = 1'b0;
    logic        req_vld  = 1'b0;
    logic [27:0] req_addr = 28'h0;
    logic        req_rdy;
    logic        rsp_vld;
    logic        rsp_rdy  = 1'b1;
    logic        rsp_hit;
    logic [2:0]  rsp_idx;
    logic [4:0]  rsp_attr;
    logic        rsp_ge_top;
    logic [10:0] obs;

    int checks   = 0;
    int failures = 0;

    ct_mmu_sysmap_region_chk #(
        .NUM_REGION(8), .PA_WIDTH(28), .ATTR_WIDTH(5), .DFLT_ATTR(DA)
    ) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
        .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_top(cfg_top),
        .cfg_attr(cfg_attr), .cfg_en(cfg_en),
        .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_attr(rsp_attr), .rsp_ge_top(rsp_ge_top)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    assign obs = {rsp_vld, rsp_hit, rsp_idx, rsp_attr, rsp_ge_top};

    function automatic logic [10:0] ev(input logic v, input logic h, input logic [2:0] i,
                                       input logic [4:0] a, input logic g);
        return {v, h, i, a, g};
    endfunction

    task automatic cfg(input logic [2:0] i, input logic [27:0] t, input logic [4:0] a,
                       input logic e);
        @(negedge forever_cpuclk);
        cfg_wen = 1'b1; cfg_idx = i; cfg_top = t; cfg_attr = a; cfg_en = e;
        @(negedge forever_cpuclk);
        cfg_wen = 1'b0;
    endtask

    task automatic lookup(input logic [27:0] a);
        @(negedge forever_cpuclk);
        req_vld = 1'b1; req_addr = a; rsp_rdy = 1'b1;
        @(negedge forever_cpuclk);
        req_vld = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== ev(1'b0, 1'b0, 3'd0, DA, 1'b0)) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, ev(1'b0, 1'b0, 3'd0, DA, 1'b0));
        end
        @(negedge forever_cpuclk); cpurst = 1'b0;
        @(negedge forever_cpuclk);
        checks++;
        if (req_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_req_rdy got=%b exp=1", req_rdy);
        end
        lookup(28'h010);
        checks++;
        if (obs !== ev(1'b1, 1'b0, 3'd0, DA, 1'b1)) begin
            failures++; $display("FAIL reset_lookup got=%h exp=%h", obs, ev(1'b1, 1'b0, 3'd0, DA, 1'b1));
        end
    endtask

    task automatic test_basic();
        logic [27:0] a [4];
        logic [10:0] e [4];
        a[0] = 28'h0FF; e[0] = ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b0);
        a[1] = 28'h100; e[1] = ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b0);
        a[2] = 28'h2FF; e[2] = ev(1'b1, 1'b1, 3'd2, 5'd3, 1'b0);
        a[3] = 28'h300; e[3] = ev(1'b1, 1'b0, 3'd0, DA, 1'b1);
        cfg(3'd0, 28'h100, 5'd1, 1'b1);
        cfg(3'd1, 28'h200, 5'd2, 1'b1);
        cfg(3'd2, 28'h300, 5'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            lookup(a[k]);
            checks++;
            if (obs !== e[k]) begin
                failures++; $display("FAIL basic[%0d] addr=%h got=%h exp=%h", k, a[k], obs, e[k]);
            end
        end
    endtask

    task automatic test_disabled();
        cfg(3'd1, 28'h200, 5'd2, 1'b0);
        lookup(28'h150);
        checks++;
        if (obs !== ev(1'b1, 1'b0, 3'd0, DA, 1'b0)) begin
            failures++; $display("FAIL disabled got=%h exp=%h", obs, ev(1'b1, 1'b0, 3'd0, DA, 1'b0));
        end
        cfg(3'd1, 28'h200, 5'd2, 1'b1);
    endtask

    task automatic test_same_cycle();
        @(negedge forever_cpuclk);
        cfg_wen = 1'b1; cfg_idx = 3'd0; cfg_top = 28'h080; cfg_attr = 5'd1; cfg_en = 1'b1;
        req_vld = 1'b1; req_addr = 28'h090; rsp_rdy = 1'b1;
        @(negedge forever_cpuclk);
        cfg_wen = 1'b0; req_vld = 1'b0;
        checks++;
        if (obs !== ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b0)) begin
            failures++; $display("FAIL same_cycle_first got=%h exp=%h", obs, ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b0));
        end
        lookup(28'h090);
        checks++;
        if (obs !== ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b0)) begin
            failures++; $display("FAIL same_cycle_second got=%h exp=%h", obs, ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ea;
        ea = ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b0);
        @(negedge forever_cpuclk); rsp_rdy = 1'b1;
        @(negedge forever_cpuclk);
        req_vld = 1'b1; req_addr = 28'h010; rsp_rdy = 1'b0;
        @(negedge forever_cpuclk);
        req_addr = 28'h110;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== ea || req_rdy !== 1'b0) begin
                failures++; $display("FAIL b2b_stall[%0d] got=%h rdy=%b exp=%h rdy=0", k, obs, req_rdy, ea);
            end
            if (k < 2) @(negedge forever_cpuclk);
        end
        rsp_rdy = 1'b1;
        @(negedge forever_cpuclk);
        req_addr = 28'h210;
        checks++;
        if (obs !== ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b0)) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h", obs, ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b0));
        end
        @(negedge forever_cpuclk);
        req_vld = 1'b0;
        checks++;
        if (obs !== ev(1'b1, 1'b1, 3'd2, 5'd3, 1'b0)) begin
            failures++; $display("FAIL b2b_third got=%h exp=%h", obs, ev(1'b1, 1'b1, 3'd2, 5'd3, 1'b0));
        end
        @(negedge forever_cpuclk);
        checks++;
        if (rsp_vld !== 1'b0) begin
            failures++; $display("FAIL b2b_drain got=%b exp=0", rsp_vld);
        end
    endtask

    task automatic test_overlap();
        logic [27:0] a [5];
        logic [10:0] e [5];
        a[0] = 28'h040; e[0] = ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b0);
        a[1] = 28'h060; e[1] = ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b1);
        a[2] = 28'h1F0; e[2] = ev(1'b1, 1'b1, 3'd1, 5'd2, 1'b1);
        a[3] = 28'h250; e[3] = ev(1'b1, 1'b0, 3'd0, DA, 1'b1);
        a[4] = 28'h050; e[4] = ev(1'b1, 1'b1, 3'd0, 5'd1, 1'b1);
        cfg(3'd2, 28'h050, 5'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            lookup(a[k]);
            checks++;
            if (obs !== e[k]) begin
                failures++; $display("FAIL overlap[%0d] addr=%h got=%h exp=%h", k, a[k], obs, e[k]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge forever_cpuclk);
        req_vld = 1'b1; req_addr = 28'h010; rsp_rdy = 1'b0;
        @(negedge forever_cpuclk);
        checks++;
        if (rsp_vld !== 1'b1) begin
            failures++; $display("FAIL inflight_pre got=%b exp=1", rsp_vld);
        end
        #2 cpurst = 1'b1;
        #1;
        checks++;
        if (obs !== ev(1'b0, 1'b0, 3'd0, DA, 1'b0)) begin
            failures++; $display("FAIL inflight_async got=%h exp=%h", obs, ev(1'b0, 1'b0, 3'd0, DA, 1'b0));
        end
        @(negedge forever_cpuclk);
        req_vld = 1'b0; rsp_rdy = 1'b1; cpurst = 1'b0;
        @(negedge forever_cpuclk);
        checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
            failures++; $display("FAIL inflight_dropped vld=%b rdy=%b exp vld=0 rdy=1", rsp_vld, req_rdy);
        end
        lookup(28'h010);
        checks++;
        if (obs !== ev(1'b1, 1'b0, 3'd0, DA, 1'b1)) begin
            failures++; $display("FAIL inflight_after got=%h exp=%h", obs, ev(1'b1, 1'b0, 3'd0, DA, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_disabled();
        test_same_cycle();
        test_back_to_back();
        test_overlap();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
